// File: rtl/simple_system_pkg.sv
// Shared definitions for the simple-system bus fabric.
//   bus_host_e            : host index assignment on the shared RAM port
//   DefaultMaxOutstanding : default depth of the response-routing ID FIFO
//   idx_width()           : width of an index into n entries, at least 1 bit
package simple_system_pkg;

  typedef enum logic [1:0] {
    CoreI  = 2'd0,
    CoreD  = 2'd1,
    Loader = 2'd2
  } bus_host_e;

  localparam int unsigned DefaultMaxOutstanding = 2;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rsp_id_fifo.sv
// In-order FIFO of host indices for requests that are still awaiting a response.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i       : store push_id_i (ignored when full)
//   pop_i        : drop the head entry (ignored when empty)
//   full_o       : Depth entries held
//   empty_o      : no entries held
//   head_o       : oldest stored index
// With a single host every stored index is 0, so head_o is constant 0.
module rsp_id_fifo
  import simple_system_pkg::*;
#(
  parameter int unsigned Depth = DefaultMaxOutstanding,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_id_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned PtrW = idx_width(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    wptr_d = do_push ? next_ptr(wptr_q) : wptr_q;
    rptr_d = do_pop  ? next_ptr(rptr_q) : rptr_q;
    cnt_d  = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      // NOTE: this storage is a handful of flops, so it is reset to keep head_o defined from time zero.
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (do_push) mem_q[wptr_q] <= push_id_i;
    end
  end

endmodule

// File: rtl/ram_host_arbiter.sv
// Round-robin arbiter sharing one request/response memory port between hosts.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   host_*_i / _o     : per-host request (req/addr/we/be/wdata), grant, response
//   device_*_o        : request muxed from the winning host
//   device_gnt_i      : device accepts the current request
//   device_rvalid_i.. : in-order device response, routed via the ID FIFO head
//   stray_rvalid_o    : response arrived with nothing outstanding
module ram_host_arbiter
  import simple_system_pkg::*;
#(
  parameter int unsigned NrHosts        = 2,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned MaxOutstanding = DefaultMaxOutstanding
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   host_req_i    [NrHosts],
  output logic                   host_gnt_o    [NrHosts],
  input  logic [AddrWidth-1:0]   host_addr_i   [NrHosts],
  input  logic                   host_we_i     [NrHosts],
  input  logic [DataWidth/8-1:0] host_be_i     [NrHosts],
  input  logic [DataWidth-1:0]   host_wdata_i  [NrHosts],
  output logic                   host_rvalid_o [NrHosts],
  output logic [DataWidth-1:0]   host_rdata_o  [NrHosts],
  output logic                   host_err_o    [NrHosts],
  output logic                   device_req_o,
  output logic [AddrWidth-1:0]   device_addr_o,
  output logic                   device_we_o,
  output logic [DataWidth/8-1:0] device_be_o,
  output logic [DataWidth-1:0]   device_wdata_o,
  input  logic                   device_gnt_i,
  input  logic                   device_rvalid_i,
  input  logic [DataWidth-1:0]   device_rdata_i,
  input  logic                   device_err_i,
  output logic                   stray_rvalid_o
);

  // Host index width; one bit even for a single host so the FIFO keeps a real port.
  localparam int unsigned IdxW = idx_width(NrHosts);

  logic [IdxW-1:0] rr_q, rr_d;
  logic [IdxW-1:0] winner;
  logic [IdxW-1:0] head;
  logic            any_req, accept, fifo_full, fifo_empty;
  int unsigned     cand;

  // Priority search over the request vector rotated to start at rr_q.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < NrHosts; k++) begin
      cand = (int'(rr_q) + k) % NrHosts;
      if (!any_req && host_req_i[cand]) begin
        any_req = 1'b1;
        winner  = IdxW'(cand);
      end
    end
  end

  // Full comes from the registered count only: a same-cycle pop does not free a slot.
  assign device_req_o   = any_req && !fifo_full && !rst_i;
  assign accept         = device_req_o && device_gnt_i;
  assign device_addr_o  = device_req_o ? host_addr_i[winner]  : '0;
  assign device_we_o    = device_req_o ? host_we_i[winner]    : 1'b0;
  assign device_be_o    = device_req_o ? host_be_i[winner]    : '0;
  assign device_wdata_o = device_req_o ? host_wdata_i[winner] : '0;
  assign stray_rvalid_o = device_rvalid_i && fifo_empty;

  always_comb begin
    for (int unsigned h = 0; h < NrHosts; h++) begin
      host_gnt_o[h]    = accept && (winner == IdxW'(h));
      host_rvalid_o[h] = device_rvalid_i && !fifo_empty && (head == IdxW'(h));
      host_err_o[h]    = device_rvalid_i && !fifo_empty && (head == IdxW'(h)) && device_err_i;
      host_rdata_o[h]  = device_rdata_i;
    end
  end

  // Pointer only advances past a host that was actually accepted.
  assign rr_d = !accept                           ? rr_q :
                (winner == IdxW'(NrHosts - 1))    ? '0   : winner + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_q <= '0;
    else       rr_q <= rr_d;
  end

  rsp_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (accept),
    .push_id_i (winner),
    .pop_i     (device_rvalid_i),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .head_o    (head)
  );

endmodule
